// File: rtl/rom_loader.sv
// UART boot loader: receives a framed program image (A5, N, 3*N data bytes,
// XOR checksum), writes 24-bit words to consecutive ROM addresses and holds
// the CPU core in reset while a load is in progress or after a failed load.
module rom_loader #(
  parameter int CLKS_PER_BIT = 234,
  parameter int TIMEOUT_CLKS = 2700000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        rom_w_enable,
  output logic [7:0]  rom_w_addr,
  output logic [23:0] rom_w_data,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error
);

  localparam int BT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [BT_W-1:0] BIT_LOAD  = BT_W'(CLKS_PER_BIT - 1);
  localparam logic [BT_W-1:0] HALF_LOAD = BT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TO_W-1:0] TO_LOAD   = TO_W'(TIMEOUT_CLKS - 1);

  // state      | meaning
  // RX_IDLE    | line idle, waiting for a falling edge
  // RX_START   | half-bit wait, confirm start bit still low
  // RX_DATA    | sampling 8 data bits, LSB first
  // RX_STOP    | sampling stop bit
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // state      | meaning
  // L_IDLE     | waiting for 0xA5 sync byte
  // L_COUNT    | next byte is the word count N (0 means 256)
  // L_DATA     | assembling and writing words
  // L_CHECK    | next byte is the XOR checksum
  typedef enum logic [1:0] {L_IDLE, L_COUNT, L_DATA, L_CHECK} ld_state_t;

  rx_state_t rx_state, rx_next;
  ld_state_t ld_state, ld_next;

  logic            rx_meta, rx_s, rx_prev;
  logic [BT_W-1:0] bit_tmr;
  logic [2:0]      bit_cnt;
  logic [7:0]      rx_byte;
  logic            byte_valid, frame_err;

  logic [TO_W-1:0] tmo_cnt;
  logic [8:0]      n_words, words_done;
  logic [7:0]      word_idx, csum;
  logic [15:0]     word;
  logic [1:0]      byte_idx;
  logic            start, word_wr, good, bad, abort;

  // Two-flop synchroniser plus delayed copy for falling-edge detect; idle high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_state <= RX_IDLE;
    else      rx_state <= rx_next;
  end

  // Receiver next-state decode.
  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_s) rx_next = RX_START;
      RX_START: if (bit_tmr == '0) rx_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_tmr == '0 && bit_cnt == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (bit_tmr == '0) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // Bit timer (down-counter), shift register and byte/error pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_tmr    <= '0;
      bit_cnt    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      unique case (rx_state)
        RX_IDLE: if (rx_prev && !rx_s) bit_tmr <= HALF_LOAD;
        RX_START: begin
          if (bit_tmr == '0) begin
            bit_tmr <= BIT_LOAD;
            bit_cnt <= '0;
          end else bit_tmr <= bit_tmr - 1'b1;
        end
        RX_DATA: begin
          if (bit_tmr == '0) begin
            rx_byte <= {rx_s, rx_byte[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            bit_tmr <= BIT_LOAD;
          end else bit_tmr <= bit_tmr - 1'b1;
        end
        RX_STOP: begin
          if (bit_tmr == '0) begin
            if (rx_s) byte_valid <= 1'b1;
            else      frame_err  <= 1'b1;
          end else bit_tmr <= bit_tmr - 1'b1;
        end
        default: bit_tmr <= '0;
      endcase
    end
  end

  // Loader state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ld_state <= L_IDLE;
    else      ld_state <= ld_next;
  end

  // Loader next-state and control strobes; abort overrides everything.
  always_comb begin
    ld_next = ld_state;
    start   = 1'b0;
    word_wr = 1'b0;
    good    = 1'b0;
    bad     = 1'b0;
    abort   = 1'b0;
    unique case (ld_state)
      L_IDLE: if (byte_valid && rx_byte == 8'hA5) begin
        start   = 1'b1;
        ld_next = L_COUNT;
      end
      L_COUNT: if (byte_valid) ld_next = L_DATA;
      L_DATA: if (byte_valid && byte_idx == 2'd2) begin
        word_wr = 1'b1;
        if (words_done + 9'd1 == n_words) ld_next = L_CHECK;
      end
      L_CHECK: if (byte_valid) begin
        good    = (rx_byte == csum);
        bad     = (rx_byte != csum);
        ld_next = L_IDLE;
      end
      default: ld_next = L_IDLE;
    endcase
    if (ld_state != L_IDLE && (frame_err || (tmo_cnt == '0 && !byte_valid))) begin
      abort   = 1'b1;
      ld_next = L_IDLE;
    end
  end

  // Loader datapath: timeout, word assembly, checksum, ROM write, status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt      <= '0;
      n_words      <= '0;
      words_done   <= '0;
      word_idx     <= '0;
      csum         <= '0;
      word         <= '0;
      byte_idx     <= '0;
      rom_w_enable <= 1'b0;
      rom_w_addr   <= '0;
      rom_w_data   <= '0;
      cpu_hold     <= 1'b0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
    end else begin
      rom_w_enable <= 1'b0;
      if (ld_state == L_IDLE || byte_valid) tmo_cnt <= TO_LOAD;
      else if (tmo_cnt != '0)                tmo_cnt <= tmo_cnt - 1'b1;
      if (start) begin
        load_done  <= 1'b0;
        load_error <= 1'b0;
        cpu_hold   <= 1'b1;
      end
      if (ld_state == L_COUNT && byte_valid) begin
        n_words    <= (rx_byte == 8'h00) ? 9'd256 : {1'b0, rx_byte};
        words_done <= '0;
        word_idx   <= '0;
        csum       <= '0;
        byte_idx   <= '0;
      end
      if (ld_state == L_DATA && byte_valid) begin
        csum     <= csum ^ rx_byte;
        word     <= {word[7:0], rx_byte};
        byte_idx <= (byte_idx == 2'd2) ? 2'd0 : byte_idx + 1'b1;
      end
      if (word_wr) begin
        rom_w_enable <= 1'b1;
        rom_w_addr   <= word_idx;
        rom_w_data   <= {word, rx_byte};
        word_idx     <= word_idx + 1'b1;
        words_done   <= words_done + 1'b1;
      end
      if (good) begin
        load_done <= 1'b1;
        cpu_hold  <= 1'b0;
      end
      if (bad || abort) load_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: stimulus pushes expected ROM writes into a
// queue, a monitor pops and compares them on every write strobe.
module tb_rom_loader;

  localparam int CPB = 8;
  localparam int TMO = 1500;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        uart_rx = 1'b1;
  logic        rom_w_enable;
  logic [7:0]  rom_w_addr;
  logic [23:0] rom_w_data;
  logic        cpu_hold, load_done, load_error;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  frame_q[$];
  logic        prev_en = 1'b0;

  rom_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx),
    .rom_w_enable(rom_w_enable), .rom_w_addr(rom_w_addr), .rom_w_data(rom_w_data),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the expected-write queue.
  always @(negedge clk) begin
    if (rst && rom_w_enable) begin
      checks++;
      if (prev_en) begin
        errors++;
        $display("FAIL strobe_width: enable high on consecutive cycles");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h expected none", rom_w_addr, rom_w_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if ({rom_w_addr, rom_w_data} !== e) begin
          errors++;
          $display("FAIL rom_write: got 0x%0h expected 0x%0h", {rom_w_addr, rom_w_data}, e);
        end
      end
    end
    prev_en = rst && rom_w_enable;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(CPB);
    end
    uart_rx = stop;
    tick(CPB);
    uart_rx = 1'b1;
  endtask

  task automatic send_frame();
    while (frame_q.size() > 0) send_byte(frame_q.pop_front(), 1'b1);
    tick(6);
  endtask

  task automatic push_good_frame();
    frame_q = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    exp_q.push_back({8'h00, 24'h112233});
    exp_q.push_back({8'h01, 24'h445566});
  endtask

  task automatic check_status(input string tag, input logic hold, input logic done, input logic err);
    @(negedge clk);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(hold));
    check({tag, "_load_done"}, 32'(load_done), 32'(done));
    check({tag, "_load_error"}, 32'(load_error), 32'(err));
  endtask

  task automatic check_drained(input string tag);
    tick(10);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // 1: reset and idle line
    tick(3);
    rst = 1'b1;
    tick(1000);
    @(negedge clk);
    check("idle_enable", 32'(rom_w_enable), 32'd0);
    check("idle_addr", 32'(rom_w_addr), 32'd0);
    check("idle_data", 32'(rom_w_data), 32'd0);
    check_status("idle", 1'b0, 1'b0, 1'b0);

    // 2: good two-word frame
    push_good_frame();
    send_byte(frame_q.pop_front(), 1'b1);
    tick(4);
    check_status("t2_after_sync", 1'b1, 1'b0, 1'b0);
    send_frame();
    check_status("t2", 1'b0, 1'b1, 1'b0);
    check_drained("t2");

    // 3: bad checksum then good frame
    push_good_frame();
    frame_q[8] = 8'h00;
    send_frame();
    check_status("t3_bad", 1'b1, 1'b0, 1'b1);
    check_drained("t3_bad");
    push_good_frame();
    send_frame();
    check_status("t3_good", 1'b0, 1'b1, 1'b0);
    check_drained("t3_good");

    // 4: junk before sync, start-bit glitch inside a frame, framing error
    frame_q = '{8'h00, 8'hFF, 8'h5A};
    send_frame();
    check_status("t4_junk", 1'b0, 1'b1, 1'b0);
    push_good_frame();
    for (int i = 0; i < 3; i++) send_byte(frame_q.pop_front(), 1'b1);
    uart_rx = 1'b0;
    tick(CPB / 4);
    uart_rx = 1'b1;
    tick(2 * CPB);
    send_frame();
    check_status("t4_glitch", 1'b0, 1'b1, 1'b0);
    check_drained("t4_glitch");
    frame_q = '{8'hA5, 8'h01, 8'h11};
    send_frame();
    send_byte(8'h22, 1'b0);
    tick(6);
    check_status("t4_frame_err", 1'b1, 1'b0, 1'b1);
    check_drained("t4_frame_err");

    // 5: timeout, then reset mid-frame
    frame_q = '{8'hA5, 8'h01, 8'h12, 8'h34};
    send_frame();
    check_status("t5_pre_timeout", 1'b1, 1'b0, 1'b0);
    tick(TMO + 200);
    check_status("t5_timeout", 1'b1, 1'b0, 1'b1);
    check_drained("t5_timeout");
    frame_q = '{8'hA5, 8'h01, 8'h12};
    send_frame();
    check_status("t5_midframe", 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("t5_rst_enable", 32'(rom_w_enable), 32'd0);
    check("t5_rst_addr_data", {rom_w_addr, rom_w_data}, 32'd0);
    check("t5_rst_flags", {29'd0, cpu_hold, load_done, load_error}, 32'd0);
    tick(3);
    rst = 1'b1;
    tick(TMO + 200);
    check_status("t5_after_rst", 1'b0, 1'b0, 1'b0);

    // 6: N=0 (256 words), word k = {k,k,k}; checksum is XOR of 0..255 = 0
    frame_q.push_back(8'hA5);
    frame_q.push_back(8'h00);
    for (int k = 0; k < 256; k++) begin
      for (int j = 0; j < 3; j++) frame_q.push_back(8'(k));
      exp_q.push_back({8'(k), {3{8'(k)}}});
    end
    frame_q.push_back(8'h00);
    send_frame();
    check_status("t6", 1'b0, 1'b1, 1'b0);
    check("t6_last_addr", 32'(rom_w_addr), 32'hFF);
    check("t6_last_data", 32'(rom_w_data), 32'hFFFFFF);
    tick(200);
    check_drained("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
